// File: rtl/hist_bin_accumulator.sv
// hist_bin_accumulator
//   Histogram bin memory. Each rising edge of Memory_add increments bin Addr
//   through a read-modify-write on a single-port, synchronous-read RAM. A host
//   read port and a full-histogram clear sweep share the same RAM port.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   Addr, Memory_add    increment request (one increment per Memory_add rise)
//   clear               single-cycle request to zero all bins
//   rd_req, rd_addr     host read, accepted only while rd_ready
//   rd_ready            IDLE with no increment or clear pending
//   rd_valid, rd_data   one-cycle read return, 2 cycles after acceptance
//   busy                clear sweep in progress
//   overflow            sticky: a bin saturated since last clear/reset
//   drop_cnt            lost increments, saturating at 255
module hist_bin_accumulator #(
  parameter int BIN_W  = 16,
  parameter int N_BINS = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       Addr,
  input  logic             Memory_add,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [6:0]       rd_addr,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [BIN_W-1:0] rd_data,
  output logic             busy,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_INC_RD, S_INC_WR, S_HOST_RD, S_HOST_RET, S_CLR
  } state_t;

  typedef struct packed {
    logic       v;
    logic [6:0] a;
  } inc_req_t;

  state_t     state;
  inc_req_t   pend;
  logic       ma_q;
  logic [6:0] inc_a, rd_a_q, clr_a;
  logic       clr_pend;

  logic       rise, accept, drop, pend_v_nxt, clr_pend_nxt;

  logic [BIN_W-1:0] mem [N_BINS];
  logic [BIN_W-1:0] q, ram_wd;
  logic [6:0]       ram_a;
  logic             ram_we;

  // The pending slot frees on the same edge INC_RD consumes it, so a rise
  // landing on that edge is still accepted.
  always_comb begin
    rise         = Memory_add & ~ma_q;
    accept       = rise & (~pend.v | (state == S_INC_RD)) & (state != S_CLR);
    drop         = rise & ~accept;
    pend_v_nxt   = accept | (pend.v & (state != S_INC_RD));
    clr_pend_nxt = (clear | clr_pend) & (state != S_IDLE);
  end

  always_comb begin
    ram_a  = '0;
    ram_we = 1'b0;
    ram_wd = '0;
    case (state)
      S_INC_RD:  ram_a = pend.a;
      S_INC_WR: begin
        ram_a  = inc_a;
        ram_we = 1'b1;
        ram_wd = (&q) ? q : q + 1'b1;   // saturate at all ones
      end
      S_HOST_RD: ram_a = rd_a_q;
      S_CLR: begin
        ram_a  = clr_a;
        ram_we = 1'b1;
      end
      default: ram_a = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_wd;
    q <= mem[ram_a];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pend     <= '0;
      ma_q     <= 1'b0;
      inc_a    <= '0;
      rd_a_q   <= '0;
      clr_a    <= '0;
      clr_pend <= 1'b0;
      rd_ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ma_q     <= Memory_add;
      pend.v   <= pend_v_nxt;
      if (accept) pend.a <= Addr;
      clr_pend <= clr_pend_nxt;
      rd_valid <= 1'b0;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (clear | clr_pend) begin
            state    <= S_CLR;
            busy     <= 1'b1;
            clr_a    <= '0;
            rd_ready <= 1'b0;
          end else if (pend.v) begin
            state    <= S_INC_RD;
            rd_ready <= 1'b0;
          end else if (rd_req & rd_ready & ~rise) begin
            // a same-cycle rise wins; the host must re-request
            state    <= S_HOST_RD;
            rd_a_q   <= rd_addr;
            rd_ready <= 1'b0;
          end else begin
            rd_ready <= ~pend_v_nxt;
          end
        end
        S_INC_RD: begin
          inc_a <= pend.a;
          state <= S_INC_WR;
        end
        S_INC_WR: begin
          if (&q) overflow <= 1'b1;
          state    <= S_IDLE;
          rd_ready <= ~pend_v_nxt & ~clr_pend_nxt;
        end
        S_HOST_RD: state <= S_HOST_RET;
        S_HOST_RET: begin
          rd_data  <= q;
          rd_valid <= 1'b1;
          state    <= S_IDLE;
          rd_ready <= ~pend_v_nxt & ~clr_pend_nxt;
        end
        S_CLR: begin
          clr_a <= clr_a + 7'd1;
          if (clr_a == 7'(N_BINS - 1)) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            rd_ready <= ~pend_v_nxt & ~clr_pend_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
